cdl_tune_ctrl: RTL and testbench
================================

CDL_TUNE_CTRL -- requirements
Module: cdl_tune_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter N_STAGES, default 16: number of coarse delay stages driven; legal range 2..64.
REQ-003 Parameter CODE_INIT, default 8: code value after reset; legal range 1..N_STAGES.
REQ-004 Parameter SETTLE, default 4: minimum number of cycles between two code changes caused by steps; legal range 1..15.
REQ-005 Parameter LOCK_CNT, default 3: number of consecutive direction reversals needed to declare lock.
REQ-006 Parameter UNLOCK_CNT, default 4: number of consecutive same-direction requests needed to leave lock.
REQ-007 Derived width CW SHALL equal clog2(N_STAGES+1).
REQ-008 Port clk, input, 1 bit: delay-line control clock.
REQ-009 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-010 Port en, input, 1 bit: step enable; 0 freezes the block.
REQ-011 Port up, input, 1 bit: request one more stage of delay.
REQ-012 Port dn, input, 1 bit: request one less stage of delay.
REQ-013 Port load, input, 1 bit: forces the code to load_code.
REQ-014 Port load_code, input, CW bits: value to load.
REQ-015 Port T, output, N_STAGES bits: thermometer stage-select bus.
REQ-016 Port Tb, output, N_STAGES bits: bitwise complement of T.
REQ-017 Port code, output, CW bits: current stage count.
REQ-018 Port locked, output, 1 bit: high while the FSM is in LOCKED.
REQ-019 Port at_min, output, 1 bit: high when code equals 1.
REQ-020 Port at_max, output, 1 bit: high when code equals N_STAGES.
REQ-021 Port sat_err, output, 1 bit: one-cycle pulse on a rejected step at a range limit.

Function
REQ-022 code SHALL always lie in the range 1..N_STAGES; T[i] SHALL be 1 exactly when i < code; Tb SHALL equal ~T; T, Tb and code SHALL be registered and change on the same edge.
REQ-023 Each change in code SHALL be exactly ±1 so that one bit of T toggles, except on a load.
REQ-024 A valid request is en=1, load=0, settle done, and exactly one of up/dn high; up=dn=1 SHALL be treated as no request.
REQ-025 A valid up request at a rising edge SHALL set code to code+1 at that same edge; a valid dn request SHALL set code to code-1 at that edge.
REQ-026 Settle: after a step-driven code change at edge t, the next step SHALL take effect no earlier than edge t+SETTLE; requests arriving earlier SHALL be dropped, not queued.
REQ-027 Saturation: a valid up at code=N_STAGES, or a valid dn at code=1, SHALL leave code unchanged and pulse sat_err for one cycle; it SHALL NOT restart the settle counter.
REQ-028 load SHALL have the highest priority and act regardless of en or settle: code becomes load_code clamped to 1..N_STAGES, the settle counter restarts, the FSM goes to TRACK, and all counters and the last direction are cleared.
REQ-029 With en=0 and load=0, code, FSM state and counters SHALL hold, and sat_err SHALL be 0.
REQ-030 The FSM SHALL have two states, TRACK and LOCKED, and SHALL remember the last accepted direction (NONE, UP or DN).
REQ-031 In TRACK: an accepted step opposite to the last direction SHALL increment the reversal count; a step in the same direction SHALL zero it; when the count reaches LOCK_CNT, the FSM SHALL go to LOCKED.
REQ-032 In LOCKED: each same-direction request, including saturated ones, SHALL increment the run count; a reversal SHALL zero it; when the count reaches UNLOCK_CNT, the FSM SHALL go to TRACK and clear its counters. Steps SHALL still be applied in LOCKED.
REQ-033 at_min and at_max SHALL be decoded combinationally from the registered code.

Reset
REQ-034 While rst_n=0, outputs SHALL be: code=CODE_INIT, T/Tb matching CODE_INIT, locked=0, sat_err=0, FSM=TRACK, last direction=NONE, counters=0, settle ready.
REQ-035 Reset asserted mid-operation SHALL take effect immediately without waiting for clk; the first step after release SHALL be accepted with no settle wait.

Structure
REQ-036 Package cdl_pkg SHALL hold the FSM state enum (TRACK, LOCKED), the direction enum (NONE, UP, DN), and default parameter constants.
REQ-037 Sub-module cdl_therm_enc, parametrised by N_STAGES, SHALL convert code to T combinationally; the parent SHALL register its output.

Verification
REQ-038 Reset release, then up held high for 20 cycles with defaults -> code goes 8→9 at the first edge, then steps every 4 cycles; T=16'h01FF after the first step.
REQ-039 code=16, then up -> code stays 16, sat_err pulses once, at_max=1; dn at code=1 -> sat_err pulses, at_min=1.
REQ-040 Alternate up/dn every 4 cycles from code 8 -> locked=1 after the 3rd reversal; then 4 same-direction requests -> locked=0.
REQ-041 load with load_code=0, then load with load_code=20 -> code=1, then code=16; locked cleared; a step is accepted 4 cycles after the load.
REQ-042 up=dn=1, or en=0 with up=1 -> code unchanged and no sat_err; rst_n low mid-settle -> code=8 immediately.

Source files
------------

// File: rtl/cdl_pkg.sv
// Shared types and default constants for the coarse delay-line tuning controller.
// Both the FSM state and the last accepted direction are exposed through cdl_dbg_t.
package cdl_pkg;

  localparam int CDL_N_STAGES   = 16;
  localparam int CDL_CODE_INIT  = 8;
  localparam int CDL_SETTLE     = 4;
  localparam int CDL_LOCK_CNT   = 3;
  localparam int CDL_UNLOCK_CNT = 4;

  localparam int CNT_W    = 8;
  localparam int SETTLE_W = 4;

  typedef enum logic {
    TRACK,
    LOCKED
  } cdl_state_e;

  typedef enum logic [1:0] {
    NONE,
    UP,
    DN
  } cdl_dir_e;

  typedef struct packed {
    cdl_state_e          state;
    cdl_dir_e            last_dir;
    logic [CNT_W-1:0]    rev_cnt;
    logic [CNT_W-1:0]    run_cnt;
    logic [SETTLE_W-1:0] settle_cnt;
  } cdl_dbg_t;

endpackage

// File: rtl/cdl_therm_enc.sv
// Combinational code-to-thermometer encoder: therm[i] = 1 exactly when i < code.
module cdl_therm_enc #(
  parameter  int N_STAGES = 16,
  localparam int CW       = $clog2(N_STAGES + 1)
) (
  input  logic [CW-1:0]       code,
  output logic [N_STAGES-1:0] therm
);

  always_comb begin
    therm = '0;
    for (int i = 0; i < N_STAGES; i++) begin
      therm[i] = (CW'(i) < code);
    end
  end

endmodule

// File: rtl/cdl_tune_ctrl.sv
// Delay-line tuning controller: steps a thermometer code by +/-1 with a settle gap,
// saturates at the range limits, and tracks lock from alternating step directions.
module cdl_tune_ctrl
  import cdl_pkg::*;
#(
  parameter  int N_STAGES   = CDL_N_STAGES,
  parameter  int CODE_INIT  = CDL_CODE_INIT,
  parameter  int SETTLE     = CDL_SETTLE,
  parameter  int LOCK_CNT   = CDL_LOCK_CNT,
  parameter  int UNLOCK_CNT = CDL_UNLOCK_CNT,
  localparam int CW         = $clog2(N_STAGES + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                up,
  input  logic                dn,
  input  logic                load,
  input  logic [CW-1:0]       load_code,
  output logic [N_STAGES-1:0] T,
  output logic [N_STAGES-1:0] Tb,
  output logic [CW-1:0]       code,
  output logic                locked,
  output logic                at_min,
  output logic                at_max,
  output logic                sat_err,
  output cdl_dbg_t            dbg
);

  localparam logic [N_STAGES-1:0] T_INIT  = {N_STAGES{1'b1}} >> (N_STAGES - CODE_INIT);
  localparam logic [CW-1:0]       CODE_MAX = CW'(N_STAGES);
  localparam logic [CW-1:0]       CODE_MIN = CW'(1);

  cdl_state_e          state_q, state_d;
  cdl_dir_e            last_q, last_d, req_dir;
  logic [CNT_W-1:0]    rev_q, rev_d, run_q, run_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [CW-1:0]       code_q, code_d;
  logic [N_STAGES-1:0] t_q, tb_q, t_enc;
  logic                sat_q, sat_d;
  logic                settle_done, req_up, req_dn, req_any, at_limit, step;

  function automatic logic [CW-1:0] clamp_code(input logic [CW-1:0] v);
    if (v < CODE_MIN)      return CODE_MIN;
    else if (v > CODE_MAX) return CODE_MAX;
    else                   return v;
  endfunction

  // Handshake-free control: a request is sampled only on an enabled, settled edge
  // with exactly one direction asserted; otherwise it is dropped, never queued.
  assign settle_done = (settle_q == '0);
  assign req_up      = en && !load && settle_done && up && !dn;
  assign req_dn      = en && !load && settle_done && dn && !up;
  assign req_any     = req_up || req_dn;
  assign req_dir     = req_up ? UP : (req_dn ? DN : NONE);
  assign at_limit    = (req_up && code_q == CODE_MAX) || (req_dn && code_q == CODE_MIN);
  assign step        = req_any && !at_limit;

  always_comb begin
    code_d   = code_q;
    state_d  = state_q;
    last_d   = last_q;
    rev_d    = rev_q;
    run_d    = run_q;
    settle_d = settle_q;
    sat_d    = 1'b0;

    if (load) begin
      code_d   = clamp_code(load_code);
      settle_d = SETTLE_W'(SETTLE - 1);
      state_d  = TRACK;
      last_d   = NONE;
      rev_d    = '0;
      run_d    = '0;
    end else if (en) begin
      if (!settle_done) settle_d = settle_q - SETTLE_W'(1);
      sat_d = at_limit;

      if (step) begin
        code_d   = req_up ? code_q + CW'(1) : code_q - CW'(1);
        settle_d = SETTLE_W'(SETTLE - 1);
        last_d   = req_dir;
      end

      case (state_q)
        TRACK: begin
          // The first step after a clear has nothing to reverse against.
          if (step && last_q != NONE) begin
            if (req_dir != last_q) begin
              if (rev_q + CNT_W'(1) == CNT_W'(LOCK_CNT)) begin
                state_d = LOCKED;
                rev_d   = '0;
                run_d   = '0;
              end else begin
                rev_d = rev_q + CNT_W'(1);
              end
            end else begin
              rev_d = '0;
            end
          end
        end
        LOCKED: begin
          // Saturated requests still count toward leaving lock.
          if (req_any) begin
            if (req_dir == last_q) begin
              if (run_q + CNT_W'(1) == CNT_W'(UNLOCK_CNT)) begin
                state_d = TRACK;
                rev_d   = '0;
                run_d   = '0;
              end else begin
                run_d = run_q + CNT_W'(1);
              end
            end else begin
              run_d = '0;
            end
          end
        end
        default: state_d = TRACK;
      endcase
    end
  end

  cdl_therm_enc #(.N_STAGES(N_STAGES)) u_therm_enc (
    .code  (code_d),
    .therm (t_enc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= TRACK;
      last_q   <= NONE;
      rev_q    <= '0;
      run_q    <= '0;
      settle_q <= '0;
      code_q   <= CW'(CODE_INIT);
      t_q      <= T_INIT;
      tb_q     <= ~T_INIT;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      rev_q    <= rev_d;
      run_q    <= run_d;
      settle_q <= settle_d;
      code_q   <= code_d;
      t_q      <= t_enc;
      tb_q     <= ~t_enc;
      sat_q    <= sat_d;
    end
  end

  assign T       = t_q;
  assign Tb      = tb_q;
  assign code    = code_q;
  assign locked  = (state_q == LOCKED);
  assign at_min  = (code_q == CODE_MIN);
  assign at_max  = (code_q == CODE_MAX);
  assign sat_err = sat_q;

  assign dbg.state      = state_q;
  assign dbg.last_dir   = last_q;
  assign dbg.rev_cnt    = rev_q;
  assign dbg.run_cnt    = run_q;
  assign dbg.settle_cnt = settle_q;

endmodule

// File: tb/tb_cdl_tune_ctrl.sv
// Directed bench for cdl_tune_ctrl with a cycle model compared on every falling edge.
module tb_cdl_tune_ctrl;
  import cdl_pkg::*;

  localparam int N  = 16;
  localparam int CI = 8;
  localparam int ST = 4;
  localparam int LK = 3;
  localparam int UL = 4;
  localparam int CW = 5;

  // clock / reset and inputs
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1, up = 1'b0, dn = 1'b0, load = 1'b0;
  logic [CW-1:0] load_code = '0;

  logic [N-1:0]  T, Tb;
  logic [CW-1:0] code;
  logic          locked, at_min, at_max, sat_err;
  cdl_dbg_t      dbg;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cdl_tune_ctrl #(
    .N_STAGES(N), .CODE_INIT(CI), .SETTLE(ST), .LOCK_CNT(LK), .UNLOCK_CNT(UL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .dn(dn),
    .load(load), .load_code(load_code),
    .T(T), .Tb(Tb), .code(code), .locked(locked),
    .at_min(at_min), .at_max(at_max), .sat_err(sat_err), .dbg(dbg)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d (0x%0h) expected %0d (0x%0h)", name, $time, act, act, exp, exp);
    end
  endtask

  // Behavioural model: integer code, elapsed enabled edges since last step, lock counts.
  int m_code = CI, m_since = ST, m_last = 0, m_rev = 0, m_run = 0;
  bit m_locked = 1'b0, m_sat = 1'b0;

  function automatic int exp_t(input int c);
    return (1 << c) - 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int dir;
    bit lim;
    if (!rst_n) begin
      m_code = CI; m_since = ST; m_last = 0; m_rev = 0; m_run = 0;
      m_locked = 1'b0; m_sat = 1'b0;
    end else begin
      m_sat = 1'b0;
      if (load) begin
        m_code = (int'(load_code) < 1) ? 1 : (int'(load_code) > N ? N : int'(load_code));
        m_since = 0; m_last = 0; m_rev = 0; m_run = 0; m_locked = 1'b0;
      end else if (en) begin
        if (m_since < ST) m_since++;
        dir = (up && !dn) ? 1 : ((dn && !up) ? -1 : 0);
        if (dir != 0 && m_since >= ST) begin
          lim = (dir > 0 && m_code == N) || (dir < 0 && m_code == 1);
          if (lim) begin
            m_sat = 1'b1;
            if (m_locked) begin
              if (dir == m_last) begin
                m_run++;
                if (m_run == UL) begin m_locked = 1'b0; m_run = 0; m_rev = 0; end
              end else m_run = 0;
            end
          end else begin
            m_code += dir;
            m_since = 0;
            if (!m_locked) begin
              if (m_last != 0) begin
                if (dir != m_last) begin
                  m_rev++;
                  if (m_rev == LK) begin m_locked = 1'b1; m_rev = 0; m_run = 0; end
                end else m_rev = 0;
              end
            end else begin
              if (dir == m_last) begin
                m_run++;
                if (m_run == UL) begin m_locked = 1'b0; m_run = 0; m_rev = 0; end
              end else m_run = 0;
            end
            m_last = dir;
          end
        end
      end
    end
  end

  // scoreboard compare on every falling edge
  always @(negedge clk) begin
    chk("code", int'(code), m_code);
    chk("T", int'(T), exp_t(m_code));
    chk("Tb", int'(Tb), ((1 << N) - 1) ^ exp_t(m_code));
    chk("locked", int'(locked), int'(m_locked));
    chk("dbg_locked", int'(dbg.state == LOCKED), int'(m_locked));
    chk("at_min", int'(at_min), int'(m_code == 1));
    chk("at_max", int'(at_max), int'(m_code == N));
    chk("sat_err", int'(sat_err), int'(m_sat));
  end

  // driver tasks
  task automatic step(input logic u, input logic d);
    up = u; dn = d;
    @(negedge clk);
    up = 1'b0; dn = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_load(input int v);
    load_code = CW'(v); load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_code", int'(code), 8);
    chk("rst_T", int'(T), 'h00FF);
    chk("rst_locked", int'(locked), 0);
    chk("rst_sat", int'(sat_err), 0);
    rst_n = 1'b1;

    // up held for 20 cycles
    up = 1'b1;
    @(negedge clk);
    chk("first_step_code", int'(code), 9);
    chk("first_step_T", int'(T), 'h01FF);
    repeat (3) @(negedge clk);
    chk("settle_hold", int'(code), 9);
    @(negedge clk);
    chk("second_step", int'(code), 10);
    repeat (15) @(negedge clk);
    up = 1'b0;
    chk("after_20_cycles", int'(code), 13);

    // saturation at both ends
    do_load(16);
    up = 1'b1;
    @(negedge clk);
    up = 1'b0;
    chk("sat_max_pulse", int'(sat_err), 1);
    chk("sat_max_code", int'(code), 16);
    chk("at_max", int'(at_max), 1);
    @(negedge clk);
    chk("sat_max_clear", int'(sat_err), 0);
    do_load(1);
    dn = 1'b1;
    @(negedge clk);
    dn = 1'b0;
    chk("sat_min_pulse", int'(sat_err), 1);
    chk("at_min", int'(at_min), 1);
    @(negedge clk);
    chk("sat_min_clear", int'(sat_err), 0);

    // lock after three reversals, unlock after four same-direction requests
    do_load(8);
    step(1, 0); step(0, 1); step(1, 0);
    chk("not_yet_locked", int'(locked), 0);
    step(0, 1);
    chk("locked_3rev", int'(locked), 1);
    chk("locked_code", int'(code), 8);
    step(0, 1); step(0, 1); step(0, 1);
    chk("still_locked", int'(locked), 1);
    step(0, 1);
    chk("unlocked", int'(locked), 0);
    chk("unlock_code", int'(code), 4);
    step(1, 0); step(0, 1); step(1, 0);
    chk("relocked", int'(locked), 1);

    // load clamping, lock clear, settle restart
    load_code = 5'd0; load = 1'b1;
    @(negedge clk);
    load = 1'b0; up = 1'b1;
    @(negedge clk);
    up = 1'b0;
    chk("load0_code", int'(code), 1);
    chk("load_clears_lock", int'(locked), 0);
    repeat (2) @(negedge clk);
    step(1, 0);
    chk("step_4_after_load", int'(code), 2);
    do_load(20);
    chk("load20_code", int'(code), 16);

    // no-request cases
    do_load(8);
    up = 1'b1; dn = 1'b1;
    repeat (4) @(negedge clk);
    up = 1'b0; dn = 1'b0;
    chk("both_dirs_code", int'(code), 8);
    en = 1'b0; up = 1'b1;
    repeat (4) @(negedge clk);
    chk("en0_code", int'(code), 8);
    chk("en0_sat", int'(sat_err), 0);
    en = 1'b1; up = 1'b0;

    // asynchronous reset mid-settle
    up = 1'b1;
    @(posedge clk);
    #2 up = 1'b0;
    chk("pre_rst_code", int'(code), 9);
    #1 rst_n = 1'b0;
    #1 chk("async_rst_code", int'(code), 8);
    chk("async_rst_T", int'(T), 'h00FF);
    @(negedge clk);
    rst_n = 1'b1;
    up = 1'b1;
    @(negedge clk);
    up = 1'b0;
    chk("post_rst_step", int'(code), 9);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
